// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and uart_tx: frame constants,
// the default bit period and the receiver FSM state encoding.
package uart_pkg;

  localparam int   UART_DATA_BITS    = 8;
  localparam logic UART_IDLE_LEVEL   = 1'b1;
  localparam int   UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RST_VAL so a reset never fabricates an edge on the output.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_p0 <= RST_VAL;
      o_sync  <= RST_VAL;
    end else begin
      meta_p0 <= i_async;
      o_sync  <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [2:0]                bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic [7:0]                data_nxt;
  logic                      valid_nxt;
  logic                      frame_err_nxt;
  logic                      overrun_nxt;
  logic                      bit_last;
  logic                      mid_bit;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad, par_bad_nxt;
  logic                      parity_err_nxt;
`endif

  uart_rx_sync #(
    .RST_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_uart_rx),
    .o_sync  (rx_s)
  );

  assign bit_last = (bit_idx == IDX_LAST);
  assign mid_bit  = (cnt == CNT_FULL);

  // cnt tracks cycles since the last sample point, so each later sample
  // lands exactly one bit period after the previous one.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    data_nxt      = o_data;
    valid_nxt     = o_valid && !i_ready;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt    = par_bad;
    parity_err_nxt = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = 1'b0;
`endif
        if (rx_s == 1'b0) begin
          state_nxt = S_START;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_START: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_HALF) begin
          if (rx_s == 1'b0) begin
            state_nxt = S_DATA;
            cnt_nxt   = CNT_W'(1);
          end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (mid_bit) begin
          cnt_nxt     = CNT_W'(1);
          shreg_nxt   = {rx_s, shreg[UART_DATA_BITS-1:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_last) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (mid_bit) begin
          cnt_nxt     = CNT_W'(1);
          par_bad_nxt = rx_s ^ (^shreg);
          state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (mid_bit) begin
          cnt_nxt = '0;
          if (rx_s == 1'b0) begin
            frame_err_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_nxt = par_bad;
`endif
            state_nxt = S_BREAK;
          end else begin
            state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              parity_err_nxt = 1'b1;
            end else
`endif
            if (!o_valid || i_ready) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
            end else begin
              overrun_nxt = 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        cnt_nxt = '0;
        if (rx_s == 1'b1) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      o_data      <= data_nxt;
      o_valid     <= valid_nxt;
      o_frame_err <= frame_err_nxt;
      o_overrun   <= overrun_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad      <= par_bad_nxt;
      o_parity_err <= parity_err_nxt;
`endif
    end
  end

  // Shift register is pure datapath; its content is only used after a
  // complete frame has overwritten every bit.
  always_ff @(posedge i_clk) begin
    shreg <= shreg_nxt;
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule
